conv_row_scheduler: RTL and testbench
=====================================

# conv_row_scheduler

Frame-level sequencer for the convolution front end: drives one full image through `input_buffer_bank` (IB) and `active_row_register` (ARR). It kicks off the IB prefetch and issues one ARR row start per output row, gated by IB readiness and downstream backpressure. It counts completed rows, then pulses `sa_done_o` to return the IB to idle. It replaces the auto-restart/done logic currently emulated by the ARR/IB joint bench, and adds config checking, abort and a watchdog.

## Interface
- `IMG_DIM_W`, 8 — width of image dimension config and row index.
- `KERNEL_W`, 4 — width of kernel-size config.
- `TIMEOUT_CYC`, 4096 — watchdog limit in cycles; must be ≥ 2.
- `clk_i` in 1 — clock.
- `rst_i` in 1 — reset; synchronous, active-high.
- `start_i` in 1 — frame start request, single-cycle; only honoured in IDLE.
- `abort_i` in 1 — abandon the current frame.
- `cfg_img_w_i` in IMG_DIM_W — image width.
- `cfg_img_h_i` in IMG_DIM_W — image height.
- `cfg_kernel_r_i` in KERNEL_W — kernel rows/cols.
- `ib_start_o` out 1 — IB prefetch start pulse.
- `ib_ready_i` in 1 — IB holds K valid rows.
- `sa_done_o` out 1 — end-of-frame pulse to the IB (`sa_done_i`).
- `arr_start_o` out 1 — ARR row start pulse.
- `arr_row_done_i` in 1 — ARR finished a row (single-cycle).
- `ds_ready_i` in 1 — downstream can accept a new output row.
- `busy_o` out 1 — frame in progress.
- `row_idx_o` out IMG_DIM_W — index of the row currently issued or running.
- `frame_done_o` out 1 — pulse when a frame completes normally.
- `cfg_err_o` out 1 — pulse when a start is rejected.
- `timeout_o` out 1 — sticky watchdog flag; cleared by an accepted start or by reset.

## Operation
- States: IDLE, PREFETCH, ISSUE, RUN, FINISH.
- **IDLE**
  - `start_i` with valid config: latch the config, set `total_rows = img_h − kernel_r + 1`, clear the row counter and `timeout_o`, pulse `ib_start_o`, go to PREFETCH.
  - Config is invalid if any of these hold: `kernel_r == 0`, `img_w == 0`, `kernel_r > img_h`, `kernel_r > img_w`.
  - `start_i` with invalid config: pulse `cfg_err_o`, stay in IDLE.
- **PREFETCH**: when `ib_ready_i == 1`, go to ISSUE.
- **ISSUE**: when `ib_ready_i && ds_ready_i`, pulse `arr_start_o` and go to RUN.
- **RUN**: on `arr_row_done_i`:
  - If `row_idx == total_rows − 1`, go to FINISH.
  - Otherwise increment `row_idx` and go to ISSUE.
- **FINISH**: for one cycle, pulse `sa_done_o` and `frame_done_o`, then go to IDLE.
- **Abort**: `abort_i` in any non-IDLE state pulses `sa_done_o` only (no `frame_done_o`) and returns to IDLE.
- **Watchdog**
  - Counts consecutive cycles spent in PREFETCH, in RUN, or in ISSUE with `ib_ready_i == 0`.
  - Clears on any state change and while ISSUE is stalled only by `ds_ready_i`.
  - Reaching `TIMEOUT_CYC`: set `timeout_o`, pulse `sa_done_o`, return to IDLE.
- **Arithmetic**: `total_rows` and `row_idx` are IMG_DIM_W bits unsigned; valid config guarantees `1 ≤ total_rows ≤ img_h`.
- **Ignored inputs**:
  - `start_i` outside IDLE.
  - `arr_row_done_i` outside RUN.
  - `abort_i` in IDLE.
- **Priority within a cycle**: reset > abort > timeout > normal transition. In IDLE, `start_i` together with `abort_i` starts normally.

## Timing
- All outputs are registered.
- Reset value is 0 on every output; the state resets to IDLE.
- `rst_i` mid-frame: next cycle all outputs are 0 and no `sa_done_o` is emitted. The IB is reset by its own reset.
- `start_i` sampled at edge N → `ib_start_o` and `busy_o` high in the cycle after edge N. `ib_start_o` is exactly one cycle wide.
- `ib_ready_i` seen at edge N in PREFETCH → earliest `arr_start_o` in the cycle after edge N+1.
- `arr_row_done_i` at edge N → `row_idx_o` updates after edge N → next `arr_start_o` earliest in the cycle after edge N+1 (one-cycle gap minimum).
- Last `arr_row_done_i` at edge N → `sa_done_o` and `frame_done_o` high in the cycle after edge N+1, each one cycle wide. `busy_o` drops in the following cycle.
- `busy_o` is high from the cycle after the accepted start through the `sa_done_o` cycle inclusive.
- `row_idx_o` holds its last value until the next accepted start, which clears it to 0.

## Test plan
- **Full LeNet frame** (28×28, k = 5, `ds_ready_i` = 1, real IB + ARR): exactly 24 `arr_start_o` pulses with `row_idx_o` 0..23; one `frame_done_o`; one `sa_done_o`; IB reads exactly 784 ROM words.
- **Bad config** (k = 0, then 29×… with h = 4, k = 5): `cfg_err_o` pulses each time, `ib_start_o` never fires, `busy_o` stays 0.
- **Backpressure**: hold `ds_ready_i` = 0 for 5000 cycles after row 3 completes → no `arr_start_o`, no timeout; release → row 4 starts 1 cycle later.
- **Abort** on the same cycle as the row-10 `arr_row_done_i` → `sa_done_o` pulse, no `frame_done_o`, `row_idx_o` stays 9; a new start then runs all 24 rows.
- **Watchdog** (IB model never raises `ib_ready_i`) → `timeout_o` set after 4096 PREFETCH cycles with a `sa_done_o` pulse; next valid start clears `timeout_o`.
- **Reset and edge configs**: `rst_i` asserted mid-RUN clears all outputs and returns to IDLE with no `sa_done_o`. Then 5×5 with k = 5 → exactly 1 row, `frame_done_o` follows the single `arr_row_done_i` with the stated 2-cycle latency.

Source files
------------

// File: rtl/conv_row_scheduler.sv
// conv_row_scheduler: frame-level sequencer for the convolution front end.
// It starts the input-buffer prefetch and issues one active-row start per
// output row. Each row start waits for buffer readiness and for downstream
// space. At end of frame, or on abort or watchdog expiry, it pulses sa_done_o
// to return the input buffer to idle.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i, abort_i    frame start request / abandon current frame
//   cfg_*_i             image width/height and kernel size, sampled on start
//   ib_start_o          prefetch start pulse to the input buffer
//   ib_ready_i          input buffer holds K valid rows
//   sa_done_o           end-of-frame pulse back to the input buffer
//   arr_start_o         active-row start pulse
//   arr_row_done_i      active-row register finished a row
//   ds_ready_i          downstream can take a new output row
//   busy_o, row_idx_o   frame in progress / current row index
//   frame_done_o        normal completion pulse
//   cfg_err_o           rejected-start pulse
//   timeout_o           sticky watchdog flag
module conv_row_scheduler #(
  parameter int unsigned IMG_DIM_W   = 8,
  parameter int unsigned KERNEL_W    = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [IMG_DIM_W-1:0] cfg_img_w_i,
  input  logic [IMG_DIM_W-1:0] cfg_img_h_i,
  input  logic [KERNEL_W-1:0]  cfg_kernel_r_i,
  output logic                 ib_start_o,
  input  logic                 ib_ready_i,
  output logic                 sa_done_o,
  output logic                 arr_start_o,
  input  logic                 arr_row_done_i,
  input  logic                 ds_ready_i,
  output logic                 busy_o,
  output logic [IMG_DIM_W-1:0] row_idx_o,
  output logic                 frame_done_o,
  output logic                 cfg_err_o,
  output logic                 timeout_o
);

  localparam int unsigned CMP_W = (IMG_DIM_W > KERNEL_W) ? IMG_DIM_W : KERNEL_W;
  localparam int unsigned WD_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_ISSUE,
    S_RUN,
    S_FINISH
  } state_e;

  state_e               state_q;
  logic [IMG_DIM_W-1:0] row_idx_q;
  logic [IMG_DIM_W-1:0] total_rows_q;
  logic [WD_W-1:0]      wd_q;
  logic                 ib_start_q;
  logic                 sa_done_q;
  logic                 arr_start_q;
  logic                 busy_q;
  logic                 frame_done_q;
  logic                 cfg_err_q;
  logic                 timeout_q;

  logic [CMP_W-1:0]     k_ext;
  logic [CMP_W-1:0]     h_ext;
  logic [CMP_W-1:0]     w_ext;
  logic                 cfg_ok;
  logic [IMG_DIM_W-1:0] total_rows_d;
  logic                 wd_count;
  logic                 wd_expire;

  // Config check and watchdog qualification.
  always_comb begin
    k_ext        = CMP_W'(cfg_kernel_r_i);
    h_ext        = CMP_W'(cfg_img_h_i);
    w_ext        = CMP_W'(cfg_img_w_i);
    cfg_ok       = (k_ext != '0) && (w_ext != '0) && (k_ext <= h_ext) && (k_ext <= w_ext);
    // Fits in IMG_DIM_W because a valid config has kernel <= height.
    total_rows_d = IMG_DIM_W'(h_ext - k_ext + CMP_W'(1));
    // An ISSUE stall caused only by downstream backpressure is legitimate.
    wd_count     = (state_q == S_PREFETCH) || (state_q == S_RUN) ||
                   ((state_q == S_ISSUE) && !ib_ready_i);
    wd_expire    = wd_count && (wd_q == WD_W'(TIMEOUT_CYC - 1));
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      row_idx_q    <= '0;
      total_rows_q <= '0;
      wd_q         <= '0;
      ib_start_q   <= 1'b0;
      sa_done_q    <= 1'b0;
      arr_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      ib_start_q   <= 1'b0;
      sa_done_q    <= 1'b0;
      arr_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      wd_q         <= wd_count ? wd_q + WD_W'(1) : '0;

      if (state_q == S_IDLE) begin
        busy_q <= 1'b0;
        if (start_i) begin
          if (cfg_ok) begin
            total_rows_q <= total_rows_d;
            row_idx_q    <= '0;
            timeout_q    <= 1'b0;
            ib_start_q   <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_PREFETCH;
          end else begin
            cfg_err_q <= 1'b1;
          end
        end
      end else begin
        // busy_o stays high through the cycle carrying sa_done_o.
        busy_q <= 1'b1;
        if (abort_i) begin
          sa_done_q <= 1'b1;
          wd_q      <= '0;
          state_q   <= S_IDLE;
        end else if (wd_expire) begin
          timeout_q <= 1'b1;
          sa_done_q <= 1'b1;
          wd_q      <= '0;
          state_q   <= S_IDLE;
        end else begin
          unique case (state_q)
            S_PREFETCH: begin
              if (ib_ready_i) begin
                wd_q    <= '0;
                state_q <= S_ISSUE;
              end
            end
            S_ISSUE: begin
              if (ib_ready_i && ds_ready_i) begin
                arr_start_q <= 1'b1;
                wd_q        <= '0;
                state_q     <= S_RUN;
              end
            end
            S_RUN: begin
              if (arr_row_done_i) begin
                wd_q <= '0;
                if (row_idx_q == total_rows_q - IMG_DIM_W'(1)) begin
                  state_q <= S_FINISH;
                end else begin
                  row_idx_q <= row_idx_q + IMG_DIM_W'(1);
                  state_q   <= S_ISSUE;
                end
              end
            end
            S_FINISH: begin
              sa_done_q    <= 1'b1;
              frame_done_q <= 1'b1;
              state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign ib_start_o   = ib_start_q;
  assign sa_done_o    = sa_done_q;
  assign arr_start_o  = arr_start_q;
  assign busy_o       = busy_q;
  assign row_idx_o    = row_idx_q;
  assign frame_done_o = frame_done_q;
  assign cfg_err_o    = cfg_err_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Testbench for conv_row_scheduler. Directed stimulus pushes the expected
// output events and expected level snapshots into queues. A monitor on the
// falling edge pops and compares them against the DUT.
module tb_conv_row_scheduler;

  localparam int unsigned IMG_DIM_W   = 8;
  localparam int unsigned KERNEL_W    = 4;
  localparam int unsigned TIMEOUT_CYC = 4096;

  localparam logic [4:0] P_IB  = 5'b10000;
  localparam logic [4:0] P_ARR = 5'b01000;
  localparam logic [4:0] P_SA  = 5'b00100;
  localparam logic [4:0] P_FD  = 5'b00010;
  localparam logic [4:0] P_ERR = 5'b00001;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 start_i;
  logic                 abort_i;
  logic [IMG_DIM_W-1:0] cfg_img_w_i;
  logic [IMG_DIM_W-1:0] cfg_img_h_i;
  logic [KERNEL_W-1:0]  cfg_kernel_r_i;
  logic                 ib_start_o;
  logic                 ib_ready_i;
  logic                 sa_done_o;
  logic                 arr_start_o;
  logic                 arr_row_done_i;
  logic                 ds_ready_i;
  logic                 busy_o;
  logic [IMG_DIM_W-1:0] row_idx_o;
  logic                 frame_done_o;
  logic                 cfg_err_o;
  logic                 timeout_o;

  conv_row_scheduler #(
    .IMG_DIM_W  (IMG_DIM_W),
    .KERNEL_W   (KERNEL_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .cfg_img_w_i   (cfg_img_w_i),
    .cfg_img_h_i   (cfg_img_h_i),
    .cfg_kernel_r_i(cfg_kernel_r_i),
    .ib_start_o    (ib_start_o),
    .ib_ready_i    (ib_ready_i),
    .sa_done_o     (sa_done_o),
    .arr_start_o   (arr_start_o),
    .arr_row_done_i(arr_row_done_i),
    .ds_ready_i    (ds_ready_i),
    .busy_o        (busy_o),
    .row_idx_o     (row_idx_o),
    .frame_done_o  (frame_done_o),
    .cfg_err_o     (cfg_err_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] pulses;
    logic [7:0] row;
    logic       busy;
    logic       tmo;
    string      name;
  } exp_t;

  exp_t ev_q[$];
  exp_t lvl_q[$];
  exp_t me;
  logic [4:0] act;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int dc, input logic [4:0] p, input logic [7:0] row,
                           input logic busy, input logic tmo, input string name);
    exp_t e;
    e.cyc = cyc + dc; e.pulses = p; e.row = row; e.busy = busy; e.tmo = tmo; e.name = name;
    ev_q.push_back(e);
  endtask

  task automatic expect_lvl(input int dc, input logic [7:0] row, input logic busy,
                            input logic tmo, input string name);
    exp_t e;
    e.cyc = cyc + dc; e.pulses = '0; e.row = row; e.busy = busy; e.tmo = tmo; e.name = name;
    lvl_q.push_back(e);
  endtask

  // Monitor: the only place that compares and counts.
  always @(negedge clk) begin
    act = {ib_start_o, arr_start_o, sa_done_o, frame_done_o, cfg_err_o};
    while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
      me = ev_q.pop_front();
      n_checks++; n_fail++;
      $display("FAIL %s missing: want pulses=%b at cyc=%0d, got no pulse", me.name, me.pulses, me.cyc);
    end
    if (act != '0) begin
      n_checks++;
      if (ev_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event cyc=%0d: got pulses=%b row=%0d, want no event", cyc, act, row_idx_o);
      end else begin
        me = ev_q.pop_front();
        if (me.cyc != cyc || me.pulses != act || me.row != row_idx_o ||
            me.busy != busy_o || me.tmo != timeout_o) begin
          n_fail++;
          $display("FAIL %s: got cyc=%0d pulses=%b row=%0d busy=%b tmo=%b, want cyc=%0d pulses=%b row=%0d busy=%b tmo=%b",
                   me.name, cyc, act, row_idx_o, busy_o, timeout_o,
                   me.cyc, me.pulses, me.row, me.busy, me.tmo);
        end
      end
    end
    while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
      me = lvl_q.pop_front();
      n_checks++;
      if (me.cyc != cyc || me.row != row_idx_o || me.busy != busy_o || me.tmo != timeout_o) begin
        n_fail++;
        $display("FAIL %s: got cyc=%0d row=%0d busy=%b tmo=%b, want cyc=%0d row=%0d busy=%b tmo=%b",
                 me.name, cyc, row_idx_o, busy_o, timeout_o, me.cyc, me.row, me.busy, me.tmo);
      end
    end
  end

  // One frame with IB ready right after prefetch; optional stall or abort.
  task automatic frame(input logic [7:0] w, input logic [7:0] h, input logic [3:0] k,
                       input int nrows, input int stall_row, input int abort_row,
                       input bit abort_on_start);
    cfg_img_w_i = w; cfg_img_h_i = h; cfg_kernel_r_i = k;
    start_i = 1'b1; abort_i = abort_on_start;
    expect_ev(1, P_IB, 8'd0, 1'b1, 1'b0, "ib_start");
    step();
    start_i = 1'b0; abort_i = 1'b0; ib_ready_i = 1'b1;
    expect_ev(2, P_ARR, 8'd0, 1'b1, 1'b0, "arr_start_first");
    step(); step();
    for (int r = 0; r < nrows; r++) begin
      step(); step();
      arr_row_done_i = 1'b1;
      if (r == abort_row) begin
        abort_i = 1'b1;
        expect_ev(1, P_SA, 8'(r), 1'b1, 1'b0, "abort_sa_done");
        step();
        arr_row_done_i = 1'b0; abort_i = 1'b0; ib_ready_i = 1'b0;
        step();
        expect_lvl(0, 8'(r), 1'b0, 1'b0, "abort_idle");
        return;
      end
      if (r == stall_row) begin
        ds_ready_i = 1'b0;
        step();
        arr_row_done_i = 1'b0;
        repeat (5000) step();
        expect_lvl(0, 8'(r + 1), 1'b1, 1'b0, "stall_hold");
        ds_ready_i = 1'b1;
        expect_ev(1, P_ARR, 8'(r + 1), 1'b1, 1'b0, "arr_after_stall");
        step();
      end else begin
        if (r == nrows - 1)
          expect_ev(2, P_SA | P_FD, 8'(r), 1'b1, 1'b0, "frame_end");
        else
          expect_ev(2, P_ARR, 8'(r + 1), 1'b1, 1'b0, "arr_start");
        step();
        arr_row_done_i = 1'b0;
        step();
      end
    end
    ib_ready_i = 1'b0;
    step();
    expect_lvl(0, 8'(nrows - 1), 1'b0, 1'b0, "idle_after_frame");
  endtask

  task automatic bad_cfg(input logic [7:0] w, input logic [7:0] h, input logic [3:0] k,
                         input logic [7:0] row, input string name);
    cfg_img_w_i = w; cfg_img_h_i = h; cfg_kernel_r_i = k;
    start_i = 1'b1;
    expect_ev(1, P_ERR, row, 1'b0, 1'b0, name);
    step();
    start_i = 1'b0;
    step();
    expect_lvl(0, row, 1'b0, 1'b0, "bad_cfg_idle");
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    cfg_img_w_i = '0; cfg_img_h_i = '0; cfg_kernel_r_i = '0;
    ib_ready_i = 1'b0; arr_row_done_i = 1'b0; ds_ready_i = 1'b1;
    step(); step();
    expect_lvl(0, 8'd0, 1'b0, 1'b0, "reset_state");
    step();
    rst_i = 1'b0;
    step();
    expect_lvl(0, 8'd0, 1'b0, 1'b0, "idle_after_reset");

    // LeNet 28x28, k=5: 24 rows.
    frame(8'd28, 8'd28, 4'd5, 24, -1, -1, 1'b0);

    // Rejected configs leave row_idx at 23.
    bad_cfg(8'd28, 8'd28, 4'd0, 8'd23, "cfg_err_k0");
    bad_cfg(8'd29, 8'd4,  4'd5, 8'd23, "cfg_err_k_gt_h");
    bad_cfg(8'd4,  8'd29, 4'd5, 8'd23, "cfg_err_k_gt_w");
    bad_cfg(8'd0,  8'd28, 4'd3, 8'd23, "cfg_err_w0");

    // Backpressure after row 3 completes.
    frame(8'd28, 8'd28, 4'd5, 24, 3, -1, 1'b0);

    // Abort together with the 10th row done; then a full frame started with abort_i high.
    frame(8'd28, 8'd28, 4'd5, 24, -1, 9, 1'b0);
    frame(8'd28, 8'd28, 4'd5, 24, -1, -1, 1'b1);

    // Watchdog: IB never ready.
    cfg_img_w_i = 8'd8; cfg_img_h_i = 8'd8; cfg_kernel_r_i = 4'd3;
    start_i = 1'b1;
    expect_ev(1, P_IB, 8'd0, 1'b1, 1'b0, "wd_ib_start");
    step();
    start_i = 1'b0;
    expect_ev(int'(TIMEOUT_CYC), P_SA, 8'd0, 1'b1, 1'b1, "wd_timeout");
    repeat (int'(TIMEOUT_CYC) + 1) step();
    expect_lvl(0, 8'd0, 1'b0, 1'b1, "wd_sticky");
    step();
    // 10x10 k=3: 8 rows; ib_start expectation checks timeout cleared.
    frame(8'd10, 8'd10, 4'd3, 8, -1, -1, 1'b0);

    // Reset mid-RUN on row 1.
    cfg_img_w_i = 8'd12; cfg_img_h_i = 8'd12; cfg_kernel_r_i = 4'd3;
    start_i = 1'b1;
    expect_ev(1, P_IB, 8'd0, 1'b1, 1'b0, "rst_ib_start");
    step();
    start_i = 1'b0; ib_ready_i = 1'b1;
    expect_ev(2, P_ARR, 8'd0, 1'b1, 1'b0, "rst_arr0");
    step(); step(); step(); step();
    arr_row_done_i = 1'b1;
    expect_ev(2, P_ARR, 8'd1, 1'b1, 1'b0, "rst_arr1");
    step();
    arr_row_done_i = 1'b0;
    step(); step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; ib_ready_i = 1'b0;
    expect_lvl(0, 8'd0, 1'b0, 1'b0, "reset_midrun");
    repeat (3) step();
    expect_lvl(0, 8'd0, 1'b0, 1'b0, "idle_after_midrun_reset");

    // 5x5 k=5: exactly one row.
    frame(8'd5, 8'd5, 4'd5, 1, -1, -1, 1'b0);

    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
